// File: rtl/jt1943_palload.sv
// Palette PROM loader: captures the 1 KB palette/priority PROM region from the ROM
// download, buffers it in a small FIFO and replays paced writes. Optional macro: JT1943_PALLOAD_CHK_EN.
module jt1943_palload #(
  parameter logic [21:0] PROM_START = 22'h3C000,
  parameter int          FIFO_AW    = 2,
  parameter int          WR_GAP     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [7:0]  prog_addr,
  output logic [3:0]  prom_din,
  output logic        prom_12a_we,
  output logic        prom_13a_we,
  output logic        prom_14a_we,
  output logic        prom_12c_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  chk
);

  localparam int              DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [3:0]      GAP_LOAD = 4'(WR_GAP - 1);
  localparam logic [10:0]     N_BYTES  = 11'd1024;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [13:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]    r_count;
  logic [3:0]          r_gap;
  logic [10:0]         r_wcnt;
  logic                r_dl, r_err;
  logic [7:0]          r_prog_addr;
  logic [3:0]          r_prom_din;
  logic [3:0]          r_we;

  logic [21:0] w_off;
  logic [13:0] w_rd;
  logic [10:0] w_wcnt_base;
  logic        w_push, w_pop, w_wr_en, w_drop, w_empty, w_full, w_rise, w_eval_fail;
  logic        w_unused_hi;

  // Unsigned wrap makes addresses below PROM_START fall outside the window too.
  assign w_off       = ioctl_addr - PROM_START;
  assign w_push      = downloading & ioctl_wr & (w_off < 22'd1024);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = ~w_empty & (r_gap == 4'd0);
  assign w_wr_en     = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_rd        = r_mem[r_rd_ptr];
  assign w_rise      = downloading & ~r_dl;
  assign w_wcnt_base = w_rise ? 11'd0 : r_wcnt;
  assign w_unused_hi = &{1'b0, ioctl_data[7:4]};

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {w_off[9:0], ioctl_data[3:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_gap       <= 4'd0;
      r_wcnt      <= 11'd0;
      r_dl        <= 1'b0;
      r_err       <= 1'b0;
      r_prog_addr <= 8'd0;
      r_prom_din  <= 4'd0;
      r_we        <= 4'd0;
      r_state     <= ST_IDLE;
    end else begin
      r_dl    <= downloading;
      r_state <= w_state_next;
      r_err   <= (r_err & ~w_rise) | w_drop | w_eval_fail;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_gap       <= GAP_LOAD;
        r_prog_addr <= w_rd[11:4];
        r_prom_din  <= w_rd[3:0];
        r_we        <= 4'b0001 << w_rd[13:12];
      end else begin
        r_we <= 4'd0;
        if (r_gap != 4'd0) r_gap <= r_gap - 4'd1;
      end
      if (w_pop && w_wcnt_base != N_BYTES) r_wcnt <= w_wcnt_base + 11'd1;
      else                                 r_wcnt <= w_wcnt_base;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_eval_fail  = 1'b0;
    if (w_rise) begin
      w_state_next = ST_LOAD;
    end else if ((r_state == ST_LOAD && !downloading && w_empty) ||
                 (r_state == ST_DRAIN && w_empty && r_gap == 4'd0)) begin
      if (r_wcnt == N_BYTES) begin
        w_state_next = ST_DONE;
      end else begin
        w_state_next = ST_IDLE;
        w_eval_fail  = 1'b1;
      end
    end else if (r_state == ST_LOAD && !downloading) begin
      w_state_next = ST_DRAIN;
    end
  end

`ifdef JT1943_PALLOAD_CHK_EN
  logic [7:0] r_chk;
  // No pops occur in IDLE or DONE, so the sum is naturally frozen there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_chk <= 8'd0;
    else        r_chk <= (w_rise ? 8'd0 : r_chk) + (w_pop ? {4'd0, w_rd[3:0]} : 8'd0);
  end
  assign chk = r_chk;
`else
  assign chk = 8'd0;
`endif

  assign prog_addr   = r_prog_addr;
  assign prom_din    = r_prom_din;
  assign prom_12a_we = r_we[0];
  assign prom_13a_we = r_we[1];
  assign prom_14a_we = r_we[2];
  assign prom_12c_we = r_we[3];
  assign busy        = ~w_empty | (|r_we);
  assign done        = (r_state == ST_DONE);
  assign err         = r_err;

endmodule

// File: tb/tb_jt1943_palload.sv
// Directed bench for jt1943_palload: full load, latency, short load, overflow burst, reset.
module tb_jt1943_palload;
  localparam logic [21:0] START = 22'h3C000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  prog_addr;
  logic [3:0]  prom_din;
  logic        prom_12a_we, prom_13a_we, prom_14a_we, prom_12c_we;
  logic        busy, done, err;
  logic [7:0]  chk;

  int checks = 0;
  int errors = 0;

  jt1943_palload dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prom_din(prom_din),
    .prom_12a_we(prom_12a_we), .prom_13a_we(prom_13a_we),
    .prom_14a_we(prom_14a_we), .prom_12c_we(prom_12c_we),
    .busy(busy), .done(done), .err(err), .chk(chk)
  );

  always #5 clk = ~clk;

  // Pulse monitor
  int cyc = 0;
  int n_pulse = 0, n_a12 = 0, n_a13 = 0, n_a14 = 0, n_c12 = 0;
  int n_multi = 0, n_close = 0, n_sp2 = 0, n_order = 0, last_cyc = 0;
  bit have_last = 0;
  bit order_on = 0;
  logic [3:0] mon_we;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    mon_we = {prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we};
    if (mon_we != 4'd0) begin
      if ($countones(mon_we) != 1) n_multi++;
      if (prom_12a_we) n_a12++;
      if (prom_13a_we) n_a13++;
      if (prom_14a_we) n_a14++;
      if (prom_12c_we) n_c12++;
      if (have_last) begin
        if (cyc - last_cyc < 2) n_close++;
        if (cyc - last_cyc == 2) n_sp2++;
      end
      have_last = 1;
      last_cyc  = cyc;
      if (order_on) begin
        if (mon_we !== 4'(1 << (n_pulse / 256)) || prog_addr !== 8'(n_pulse % 256) ||
            prom_din !== 4'(n_pulse % 16))
          n_order++;
      end
      n_pulse++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  function automatic logic [7:0] exp_chk(input logic [7:0] v);
`ifdef JT1943_PALLOAD_CHK_EN
    return v;
`else
    return 8'd0 & v;
`endif
  endfunction

  int sum;
  int snap_p, snap_sp2;

  initial begin
    // Reset state
    ticks(3);
    check("rst_prog_addr", 32'(prog_addr), 0);
    check("rst_we", 32'({prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we}), 0);
    check("rst_busy_done_err", 32'({busy, done, err}), 0);
    check("rst_chk", 32'(chk), 0);
    rst_n = 1'b1;
    ticks(2);

    // Full sequential download, one byte every 4 clocks, plus two out-of-window bytes
    downloading = 1'b1;
    order_on = 1;
    tick();
    send(START - 22'd1, 8'h3C);
    ticks(3);
    sum = 0;
    for (int i = 0; i < 1024; i++) begin
      send(START + 22'(i), 8'h50 | 8'(i % 16));
      sum += i % 16;
      ticks(3);
    end
    send(START + 22'd1024, 8'h0A);
    ticks(5);
    check("full_busy_idle", 32'(busy), 0);
    check("full_done_early", 32'(done), 0);
    downloading = 1'b0;
    tick();
    order_on = 0;
    check("full_done", 32'(done), 1);
    check("full_err", 32'(err), 0);
    check("full_prog_addr", 32'(prog_addr), 32'hFF);
    check("full_prom_din", 32'(prom_din), 32'hF);
    check("full_n12a", 32'(n_a12), 256);
    check("full_n13a", 32'(n_a13), 256);
    check("full_n14a", 32'(n_a14), 256);
    check("full_n12c", 32'(n_c12), 256);
    check("full_order", 32'(n_order), 0);
    check("full_chk", 32'(chk), 32'(exp_chk(8'(sum))));

    // Single byte latency into 14A
    downloading = 1'b1;
    tick();
    check("restart_done_clr", 32'(done), 0);
    check("restart_chk_clr", 32'(chk), 0);
    send(START + 22'h2A5, 8'hB7);
    check("lat_no_pulse_yet", 32'({prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we}), 0);
    check("lat_busy", 32'(busy), 1);
    tick();
    check("lat_we", 32'({prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we}), 32'b0100);
    check("lat_prog_addr", 32'(prog_addr), 32'hA5);
    check("lat_prom_din", 32'(prom_din), 32'h7);
    tick();
    check("lat_pulse_end", 32'({prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we}), 0);
    check("lat_hold_addr", 32'(prog_addr), 32'hA5);
    check("lat_chk", 32'(chk), 32'(exp_chk(8'h07)));
    downloading = 1'b0;
    ticks(2);
    check("lat_short_err", 32'(err), 1);

    // Download stops after 512 bytes
    downloading = 1'b1;
    tick();
    check("half_err_clr", 32'(err), 0);
    snap_p = n_pulse;
    for (int i = 0; i < 512; i++) begin
      send(START + 22'(i), 8'(i));
      tick();
    end
    ticks(4);
    downloading = 1'b0;
    ticks(4);
    check("half_pulses", 32'(n_pulse - snap_p), 512);
    check("half_err", 32'(err), 1);
    check("half_done", 32'(done), 0);

    // 12 back-to-back strobes overflow the 4-deep FIFO twice
    downloading = 1'b1;
    tick();
    check("burst_err_clr", 32'(err), 0);
    snap_p = n_pulse;
    snap_sp2 = n_sp2;
    for (int i = 0; i < 12; i++) begin
      ioctl_addr = START + 22'h100 + 22'(i);
      ioctl_data = 8'(i);
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    check("burst_err", 32'(err), 1);
    ticks(30);
    check("burst_pulses", 32'(n_pulse - snap_p), 10);
    check("burst_spacing2", 32'(n_sp2 - snap_sp2), 9);
    downloading = 1'b0;
    ticks(3);

    // Reset with three entries pending
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ioctl_addr = START + 22'h300 + 22'(i);
      ioctl_data = 8'h0F;
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    check("rst2_busy_before", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    downloading = 1'b0;
    #1;
    check("rst2_prog_addr", 32'(prog_addr), 0);
    check("rst2_din_we", 32'({prom_din, prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we}), 0);
    check("rst2_flags", 32'({busy, done, err}), 0);
    check("rst2_chk", 32'(chk), 0);
    snap_p = n_pulse;
    ticks(2);
    rst_n = 1'b1;
    ticks(20);
    check("rst2_no_pulses", 32'(n_pulse - snap_p), 0);
    check("rst2_busy_after", 32'(busy), 0);

    // Global pulse properties
    check("glob_onehot", 32'(n_multi), 0);
    check("glob_min_gap", 32'(n_close), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
